// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package dmem_arb_pkg;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} arb_state_t;
  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t id;
    logic     we;
  } inflight_t;
endpackage

// File: rtl/dmem_arb_prio2.sv
// Two-way combinational grant: a pending force wins, otherwise prefer_i breaks ties.
module arb_prio2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  port_id_t   prefer_i,
  input  logic [1:0] force_i,
  output logic [1:0] grant_o
);
  always_comb begin
    grant_o = valid_i;
    if (|(force_i & valid_i)) grant_o = force_i & valid_i;
    else if (&valid_i)        grant_o = prefer_i ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port BRAM between the core LSU (port 0) and the loader/DMA (port 1).
// Define DMEM_ARB_RR_EN for round-robin arbitration in IDLE; default is fixed priority to port 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [1:0]              req_lock,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_di,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);
  localparam int CNT_W = (MAX_LOCK > 2) ? $clog2(MAX_LOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       force_q, force_d;
  inflight_t        infl_q, infl_d;
  logic [1:0]       arb_gnt, gnt;
  port_id_t         prefer, gid, own;

`ifdef DMEM_ARB_RR_EN
  port_id_t rr_q, rr_d;
  assign prefer = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (state_q == IDLE && |gnt) rr_d = ~gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end
`else
  assign prefer = 1'b0;
`endif

  arb_prio2 u_prio (
    .valid_i  (req_valid),
    .prefer_i (prefer),
    .force_i  (force_q),
    .grant_o  (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    force_d = force_q;
    gnt     = '0;
    own     = (state_q == LOCK1);
    case (state_q)
      IDLE: begin
        gnt = arb_gnt;
        if (|arb_gnt) begin
          force_d = '0;
          if (req_lock[arb_gnt[1]]) begin
            state_d = arb_gnt[1] ? LOCK1 : LOCK0;
            cnt_d   = '0;
          end
        end
      end
      LOCK0, LOCK1: begin
        // Owner keeps exclusivity this cycle even when it is releasing or timing out.
        gnt[own] = req_valid[own];
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == CNT_MAX && req_valid[~own]) begin
          state_d = IDLE;
          force_d = own ? 2'b01 : 2'b10;
        end else if (!req_lock[own]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) gnt = '0;
  end

  assign req_ready = gnt;
  assign gid       = gnt[1];
  assign mem_we    = |gnt & req_we[gid];
  assign mem_addr  = ~|gnt ? '0 : gid ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : req_addr[ADDR_WIDTH-1:0];
  assign mem_di    = ~|gnt ? '0 : gid ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  always_comb begin
    infl_d.valid = |gnt;
    infl_d.id    = gid;
    infl_d.we    = mem_we;
  end

  // Reset squashes a response already in flight, not just the next one.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (infl_q.valid && !rst) begin
      resp_valid[infl_q.id] = 1'b1;
      if (!infl_q.we) resp_rdata = mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      force_q <= '0;
      infl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
      infl_q  <= infl_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed grant/lock/reset scenarios plus a random phase.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid, req_ready, req_we, req_lock, resp_valid;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [31:0] resp_rdata, mem_di, mem_dout;
  logic        mem_we;
  logic [15:0] mem_addr;

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_LOCK(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM; only the low 256 words are exercised.
  logic [31:0] ram    [256];
  logic [31:0] shadow [256];

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return 32'hA5A5_0000 | {16'h0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem_dout <= mem_di;
      ram[mem_addr[7:0]] = mem_di;
    end else begin
      mem_dout <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic id; logic [31:0] rdata; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [1:0]  acc, exp_v;
  logic [31:0] exp_d, a_w, d_w;
  logic        aid;

  // Every accept pushes its expected response; responses are popped one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      chk("rst_resp_valid", resp_valid, 2'b00);
      chk("rst_req_ready", req_ready, 2'b00);
      chk("rst_mem_we", mem_we, 1'b0);
    end else begin
      exp_v = 2'b00;
      exp_d = '0;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_v[e.id] = 1'b1;
        exp_d = e.rdata;
      end
      chk("resp_valid", resp_valid, exp_v);
      chk("resp_rdata", resp_rdata, exp_d);
      acc = req_valid & req_ready;
      chk("ready_only_valid", req_ready & ~req_valid, 2'b00);
      chk("one_grant", 64'($countones(req_ready) <= 1), 1);
      if (acc != 2'b00) begin
        aid = acc[1];
        a_w = aid ? {16'h0, req_addr[31:16]} : {16'h0, req_addr[15:0]};
        d_w = aid ? req_wdata[63:32] : req_wdata[31:0];
        chk("mem_addr", mem_addr, a_w);
        chk("mem_we", mem_we, req_we[aid]);
        if (req_we[aid]) begin
          chk("mem_di", mem_di, d_w);
          shadow[a_w[7:0]] = d_w;
          sb.push_back('{id: aid, rdata: 32'h0});
        end else begin
          sb.push_back('{id: aid, rdata: shadow[a_w[7:0]]});
        end
      end else begin
        chk("idle_mem_we", mem_we, 1'b0);
        chk("idle_mem_addr", mem_addr, 16'h0);
      end
    end
  end

  task automatic drv(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                     input logic [15:0] a0, input logic [15:0] a1,
                     input logic [31:0] d0 = 32'h0, input logic [31:0] d1 = 32'h0);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy(input string tag, input logic [1:0] exp);
    @(negedge clk);
    chk(tag, req_ready, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = init_val(16'(i));
      shadow[i] = init_val(16'(i));
    end
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    do_reset();

    // Both valid reads: port 0 first, then port 1.
    drv(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020);
    rdy("t1_first_grant", 2'b01);
    tick();
    drv(2'b10, 2'b00, 2'b00, 16'h0010, 16'h0020);
    rdy("t1_second_grant", 2'b10);
    chk("t1_resp0_valid", resp_valid, 2'b01);
    chk("t1_resp0_data", resp_rdata, init_val(16'h0010));
    tick();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    rdy("t1_idle", 2'b00);
    chk("t1_resp1_valid", resp_valid, 2'b10);
    chk("t1_resp1_data", resp_rdata, init_val(16'h0020));
    tick();
    drain();

    // Continuous contention: alternates under round-robin, port 0 under fixed priority.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drv(2'b11, 2'b00, 2'b00, 16'(i), 16'(i + 8));
      rdy($sformatf("t2_grant_%0d", i), (RR && (i % 2 == 1)) ? 2'b10 : 2'b01);
      tick();
    end
    drain();

    // Write then read same address returns the new data.
    do_reset();
    drv(2'b01, 2'b01, 2'b00, 16'h0005, 16'h0, 32'hDEAD_BEEF);
    rdy("t3_wr_grant", 2'b01);
    chk("t3_we_high", mem_we, 1'b1);
    tick();
    drv(2'b01, 2'b00, 2'b00, 16'h0005, 16'h0);
    rdy("t3_rd_grant", 2'b01);
    chk("t3_we_low", mem_we, 1'b0);
    chk("t3_wr_resp_valid", resp_valid, 2'b01);
    chk("t3_wr_resp_data", resp_rdata, 32'h0);
    tick();
    drv(2'b00, 2'b00, 2'b00, 16'h0, 16'h0);
    rdy("t3_idle", 2'b00);
    chk("t3_rd_data", resp_rdata, 32'hDEAD_BEEF);
    chk("t3_we_idle", mem_we, 1'b0);
    tick();
    drain();

    // Port 1 lock times out after 16 contended cycles; port 0 is forced in next.
    do_reset();
    drv(2'b10, 2'b00, 2'b10, 16'h0, 16'h0030);
    rdy("t4_lock_grant", 2'b10);
    tick();
    for (int i = 0; i < 16; i++) begin
      drv(2'b11, 2'b00, 2'b10, 16'h0040, 16'(16'h0031 + i));
      rdy($sformatf("t4_hold_%0d", i), 2'b10);
      tick();
    end
    drv(2'b11, 2'b00, 2'b10, 16'h0040, 16'h0050);
    rdy("t4_forced", 2'b01);
    tick();
    drv(2'b01, 2'b00, 2'b00, 16'h0041, 16'h0);
    rdy("t4_back_idle", 2'b01);
    tick();
    drain();

    // Port 0 lock: exclusive even when idle, releases one cycle after req_lock drops.
    do_reset();
    drv(2'b11, 2'b00, 2'b01, 16'h0060, 16'h0070);
    rdy("t5_lock_grant", 2'b01);
    tick();
    drv(2'b11, 2'b00, 2'b01, 16'h0061, 16'h0070);
    rdy("t5_hold", 2'b01);
    tick();
    drv(2'b10, 2'b00, 2'b01, 16'h0, 16'h0070);
    rdy("t5_exclusive", 2'b00);
    tick();
    drv(2'b11, 2'b00, 2'b00, 16'h0062, 16'h0070);
    rdy("t5_release_cycle", 2'b01);
    tick();
    drv(2'b10, 2'b00, 2'b00, 16'h0, 16'h0071);
    rdy("t5_port1_eligible", 2'b10);
    tick();
    drain();

    // Reset right after a read accept drops the response.
    do_reset();
    drv(2'b01, 2'b00, 2'b00, 16'h0080, 16'h0);
    rdy("t6_accept", 2'b01);
    tick();
    rst = 1'b1;
    drv(2'b11, 2'b00, 2'b00, 16'h0081, 16'h0082);
    rdy("t6_rst_ready", 2'b00);
    chk("t6_rst_resp", resp_valid, 2'b00);
    tick();
    rst = 1'b0;
    drv(2'b10, 2'b00, 2'b00, 16'h0, 16'h0083);
    rdy("t6_post_rst_grant", 2'b10);
    chk("t6_post_rst_resp", resp_valid, 2'b00);
    tick();
    drain();

    // Random traffic over a small address window; scoreboard checks data.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drv(2'($urandom), 2'($urandom), ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00,
          16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)), $urandom, $urandom);
      tick();
    end
    drain();

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
